ixc_assign_sched: RTL and testbench
===================================

Name: ixc_assign_sched

Overview:
Round-robin scheduler that shares one W-bit assignment path between N requesters. Each requester presents a value with a request. The block grants one requester at a time, registers its value onto the shared output L, and holds it there for HOLD cycles. It sits in front of the per-bit ixc_assign bit-copy instances in IXCOM_TEMP_LIBRARY. L feeds their R input directly, so the assign stays purely combinational while ownership of the value is sequenced here.

Parameters:
W, 5, width of the assigned value (matches the 5-bit assign instance)
N, 4, number of requesters, 2..16
HOLD, 1, cycles each granted value is held with l_valid=1 before the next grant, 1..255

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
req  input  N  request, one bit per requester; level-sensitive
r_data  input  N*W  requester values; requester i occupies bits [i*W +: W]
ack  output  N  one-cycle grant pulse, one-hot or zero
L  output  W  shared assigned value (registered)
l_valid  output  1  high while L carries a value inside its hold window
grant_id  output  max(1,$clog2(N))  index of the requester whose value is on L
busy  output  1  high in state DRIVE

Behaviour:
- Reset (asynchronous, rst_n low):
  - L=0, l_valid=0, ack=0, grant_id=0, busy=0.
  - Round-robin pointer ptr=0, hold counter cnt=0, FSM=IDLE.
  - Applies immediately, including mid-hold; the in-flight grant is abandoned and no ack is emitted.
- FSM states: IDLE, DRIVE.
- Arbitration point: a cycle in IDLE, or the last DRIVE cycle (cnt==HOLD-1).
- Eligible set: req masked by ~ack. The requester acked this cycle cannot be re-granted next cycle, so there is never a double capture while it drops req.
- Winner selection:
  - Winner = first eligible index searching ptr, ptr+1, … mod N.
  - On grant, ptr <= (winner+1) mod N.
- Grant at arbitration edge t, visible from t+1:
  - L <= r_data[winner]; grant_id <= winner.
  - ack[winner] = 1 for exactly one cycle; l_valid = 1.
  - FSM = DRIVE, cnt = 0.
- Latency: req high at edge t in IDLE → L, ack and l_valid valid at t+1.
- DRIVE:
  - cnt increments each cycle.
  - At cnt==HOLD-1 with an eligible request: new grant, back-to-back with no gap; l_valid stays 1.
  - At cnt==HOLD-1 with none eligible: FSM=IDLE, l_valid=0, busy=0.
- IDLE:
  - L and grant_id retain their last values (assign hold semantics).
  - l_valid=0.
- Requester obligations:
  - Hold req and r_data stable until ack is seen.
  - Deassert req in the cycle after ack, or keep it high to request again; it is re-eligible one cycle after its ack.
  - Dropping req before ack withdraws the request; no error is flagged.
- Simultaneous requests: resolved strictly by the rotating pointer. With N requests held continuously, each requester is served once every N grants.
- HOLD=1: a grant is possible every cycle; ack pulses alternate across requesters.
- Width rules:
  - cnt width is 8 bits.
  - ptr wrap from N-1 to 0 is explicit, and also correct for non-power-of-2 N.

Optional Feature:
IXC_ASSIGN_SCHED_PARITY_EN
- Defined:
  - Adds output l_par (1 bit) = XOR of L, registered together with L, so it is always coherent with L.
  - Adds input r_par (N bits) carrying the requester-supplied parity.
  - Adds output par_err (1 bit), sticky. It is set when r_par[winner] != ^r_data[winner] at a grant, and cleared only by reset.
  - Reset values: l_par=0, par_err=0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-DRIVE with HOLD=3 → L=0, l_valid=0, ack=0, busy=0 in the same cycle; after release with req=0, outputs stay at reset values.
- Single request, HOLD=1: req=0001, r_data[0]=5'h15 at edge t → at t+1 L=5'h15, ack=0001, l_valid=1, grant_id=0; req dropped → at t+2 l_valid=0, L stays 5'h15.
- Round robin, HOLD=1: req=1111 held, values 5'h01/02/04/08 → grant_id sequence 0,1,2,3,0 on consecutive cycles; each ack is one cycle; no requester is granted twice in a row.
- HOLD=4, back-to-back: req=0110 → L holds requester 1's value for 4 cycles with l_valid=1, then switches to requester 2 with no l_valid gap; busy=1 throughout.
- Pointer wrap, N=3: grant to index 2, then req=011 → next grant_id=0 (ptr wrapped to 0, not 1).
- Parity (macro defined): r_data[1]=5'h07 with r_par[1]=0 → at grant l_par=1, par_err=1 and sticky; reset clears it.

Source files
------------

// File: rtl/ixc_assign_sched.sv
// Round-robin owner of a shared W-bit assign path; registers the winner's value onto L for HOLD cycles.
// Optional requester parity check under `ifdef IXC_ASSIGN_SCHED_PARITY_EN. States: IDLE | no owner, DRIVE | L held for owner.
module ixc_assign_sched #(
  parameter int W    = 5,
  parameter int N    = 4,
  parameter int HOLD = 1,
  localparam int GW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] r_data,
`ifdef IXC_ASSIGN_SCHED_PARITY_EN
  input  logic [N-1:0]   r_par,
  output logic           l_par,
  output logic           par_err,
`endif
  output logic [N-1:0]   ack,
  output logic [W-1:0]   L,
  output logic           l_valid,
  output logic [GW-1:0]  grant_id,
  output logic           busy
);

  typedef enum logic {IDLE, DRIVE} state_t;

  localparam logic [7:0]    HOLD_LAST = 8'(HOLD - 1);
  localparam logic [GW-1:0] PTR_LAST  = GW'(N - 1);

  state_t          state_q, state_d;
  logic [7:0]      cnt_q;
  logic [GW-1:0]   ptr_q;
  logic [N-1:0]    elig;
  logic            found;
  logic [GW-1:0]   win;
  logic [GW-1:0]   ptr_next;
  logic            arb;
  logic            grant;
  logic [W-1:0]    win_data;
  int              idx;

  // The requester acked this cycle is masked so it is never captured twice.
  always_comb begin
    elig  = req & ~ack;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && elig[GW'(idx)]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end

  assign ptr_next = (win == PTR_LAST) ? '0 : win + 1'b1;
  assign arb      = (state_q == IDLE) || (cnt_q == HOLD_LAST);
  assign grant    = arb && found;
  assign win_data = r_data[int'(win)*W +: W];
  assign busy     = (state_q == DRIVE);

  always_comb begin
    state_d = state_q;
    if (grant)    state_d = DRIVE;
    else if (arb) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      ack      <= '0;
      L        <= '0;
      l_valid  <= 1'b0;
      grant_id <= '0;
`ifdef IXC_ASSIGN_SCHED_PARITY_EN
      l_par    <= 1'b0;
      par_err  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ack     <= '0;
      if (grant) begin
        L          <= win_data;
        grant_id   <= win;
        ack[win]   <= 1'b1;
        ptr_q      <= ptr_next;
        cnt_q      <= '0;
        l_valid    <= 1'b1;
`ifdef IXC_ASSIGN_SCHED_PARITY_EN
        l_par      <= ^win_data;
        if (r_par[win] != ^win_data) par_err <= 1'b1;
`endif
      end else if (arb) begin
        cnt_q   <= '0;
        l_valid <= 1'b0;
      end else begin
        cnt_q   <= cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ixc_assign_sched.sv
// Bench for ixc_assign_sched: two instances (N=4/HOLD=1 and N=3/HOLD=3) against an ownership-window model.
// Parity checks are compiled in when IXC_ASSIGN_SCHED_PARITY_EN is defined.
module tb_ixc_assign_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [3:0]  req_a, par_a, ack_a;
  logic [19:0] data_a;
  logic [4:0]  L_a;
  logic        lv_a, busy_a, lpar_a, perr_a;
  logic [1:0]  gid_a;

  logic [2:0]  req_b, par_b, ack_b;
  logic [14:0] data_b;
  logic [4:0]  L_b;
  logic        lv_b, busy_b, lpar_b, perr_b;
  logic [1:0]  gid_b;

  int n_assert = 0;
  int n_fail   = 0;

  ixc_assign_sched #(.W(5), .N(4), .HOLD(1)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .r_data(data_a),
`ifdef IXC_ASSIGN_SCHED_PARITY_EN
    .r_par(par_a), .l_par(lpar_a), .par_err(perr_a),
`endif
    .ack(ack_a), .L(L_a), .l_valid(lv_a), .grant_id(gid_a), .busy(busy_a)
  );

  ixc_assign_sched #(.W(5), .N(3), .HOLD(3)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .r_data(data_b),
`ifdef IXC_ASSIGN_SCHED_PARITY_EN
    .r_par(par_b), .l_par(lpar_b), .par_err(perr_b),
`endif
    .ack(ack_b), .L(L_b), .l_valid(lv_b), .grant_id(gid_b), .busy(busy_b)
  );

`ifndef IXC_ASSIGN_SCHED_PARITY_EN
  assign lpar_a = 1'b0;
  assign perr_a = 1'b0;
  assign lpar_b = 1'b0;
  assign perr_b = 1'b0;
`endif

  // Model: an owner holds L for `hold` cycles; m_rem counts the cycles left in its window.
  int          m_ptr[2], m_rem[2], m_gid[2];
  logic [15:0] m_ack[2];
  logic [4:0]  m_L[2];
  bit          m_valid[2], m_lpar[2], m_perr[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 0; m_rem[k] = 0; m_gid[k] = 0; m_ack[k] = '0;
      m_L[k] = '0; m_valid[k] = 0; m_lpar[k] = 0; m_perr[k] = 0;
    end
  endtask

  task automatic model_tick(input int k, input int n, input int hold,
                            input logic [15:0] rq, input logic [79:0] rd, input logic [15:0] rp);
    int w, j;
    logic [15:0] elig;
    logic [4:0] v;
    elig = rq & ~m_ack[k];
    w = -1;
    if (!m_valid[k] || m_rem[k] == 1) begin
      for (int s = 0; s < n; s++) begin
        j = (m_ptr[k] + s) % n;
        if (w < 0 && elig[j[3:0]]) w = j;
      end
      if (w >= 0) begin
        v = rd[w*5 +: 5];
        m_L[k] = v; m_gid[k] = w; m_ack[k] = 16'(1) << w;
        m_valid[k] = 1; m_rem[k] = hold; m_ptr[k] = (w + 1) % n;
        m_lpar[k] = ^v;
        if (rp[w[3:0]] != ^v) m_perr[k] = 1;
      end else begin
        m_valid[k] = 0; m_ack[k] = '0;
      end
    end else begin
      m_rem[k] = m_rem[k] - 1;
      m_ack[k] = '0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_ack",   32'(ack_a),  32'(m_ack[0]));
    chk("a_L",     32'(L_a),    32'(m_L[0]));
    chk("a_valid", 32'(lv_a),   32'(m_valid[0]));
    chk("a_gid",   32'(gid_a),  32'(m_gid[0]));
    chk("a_busy",  32'(busy_a), 32'(m_valid[0]));
    chk("b_ack",   32'(ack_b),  32'(m_ack[1]));
    chk("b_L",     32'(L_b),    32'(m_L[1]));
    chk("b_valid", 32'(lv_b),   32'(m_valid[1]));
    chk("b_gid",   32'(gid_b),  32'(m_gid[1]));
    chk("b_busy",  32'(busy_b), 32'(m_valid[1]));
`ifdef IXC_ASSIGN_SCHED_PARITY_EN
    chk("a_lpar",  32'(lpar_a), 32'(m_lpar[0]));
    chk("a_perr",  32'(perr_a), 32'(m_perr[0]));
    chk("b_lpar",  32'(lpar_b), 32'(m_lpar[1]));
    chk("b_perr",  32'(perr_b), 32'(m_perr[1]));
`endif
  endtask

  task automatic step();
    model_tick(0, 4, 1, {12'b0, req_a}, {60'b0, data_a}, {12'b0, par_a});
    model_tick(1, 3, 3, {13'b0, req_b}, {65'b0, data_b}, {13'b0, par_b});
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Called 1 time unit after an edge; asserts reset mid-cycle and checks the asynchronous effect.
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = '0; data_a = '0; par_a = '0;
    req_b = '0; data_b = '0; par_b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Reset in the middle of a HOLD=3 window on instance b.
    req_b = 3'b001; data_b[4:0] = 5'h0A; par_b[0] = ^data_b[4:0];
    step();
    chk("b_first_L", 32'(L_b), 32'h0A);
    req_b = '0;
    step();
    chk("b_mid_busy", 32'(busy_b), 32'd1);
    pulse_reset();
    chk("rst_L_b", 32'(L_b), 32'd0);
    chk("rst_valid_b", 32'(lv_b), 32'd0);
    repeat (2) step();

    // Single request, HOLD=1.
    req_a = 4'b0001; data_a[4:0] = 5'h15; par_a[0] = ^data_a[4:0];
    step();
    chk("single_L", 32'(L_a), 32'h15);
    chk("single_ack", 32'(ack_a), 32'h1);
    chk("single_valid", 32'(lv_a), 32'd1);
    chk("single_gid", 32'(gid_a), 32'd0);
    req_a = '0;
    step();
    chk("drop_valid", 32'(lv_a), 32'd0);
    chk("drop_L_held", 32'(L_a), 32'h15);

    // Round robin from ptr=0 with all four requesting.
    pulse_reset();
    req_a = 4'b1111; data_a = {5'h08, 5'h04, 5'h02, 5'h01};
    par_a = {^data_a[19:15], ^data_a[14:10], ^data_a[9:5], ^data_a[4:0]};
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_gid", 32'(gid_a), 32'(i % 4));
      chk("rr_ack", 32'(ack_a), 32'(1) << (i % 4));
    end
    req_a = '0;
    step();

    // Back-to-back HOLD=3 windows on b, then pointer wrap 2 -> 0.
    req_b = 3'b110; data_b = {5'h13, 5'h12, 5'h11};
    par_b = {^data_b[14:10], ^data_b[9:5], ^data_b[4:0]};
    for (int i = 0; i < 3; i++) begin
      step();
      chk("b2b_L1", 32'(L_b), 32'h12);
      chk("b2b_valid", 32'(lv_b), 32'd1);
    end
    step();
    chk("b2b_L2", 32'(L_b), 32'h13);
    chk("b2b_gid2", 32'(gid_b), 32'd2);
    req_b = 3'b011;
    repeat (3) step();
    chk("wrap_gid", 32'(gid_b), 32'd0);
    req_b = '0;
    repeat (4) step();

`ifdef IXC_ASSIGN_SCHED_PARITY_EN
    req_a = 4'b0010; data_a[9:5] = 5'h07; par_a[1] = 1'b0;
    step();
    chk("par_lpar", 32'(lpar_a), 32'd1);
    chk("par_err", 32'(perr_a), 32'd1);
    req_a = '0;
    repeat (2) step();
    chk("par_sticky", 32'(perr_a), 32'd1);
    pulse_reset();
    chk("par_cleared", 32'(perr_a), 32'd0);
`endif

    // Randomized traffic; parity mostly correct with occasional corruption.
    for (int c = 0; c < 400; c++) begin
      req_a = 4'($urandom_range(0, 15));
      data_a = 20'($urandom);
      for (int i = 0; i < 4; i++)
        par_a[i] = (^data_a[i*5 +: 5]) ^ ($urandom_range(0, 19) == 0);
      req_b = 3'($urandom_range(0, 7));
      data_b = 15'($urandom);
      for (int i = 0; i < 3; i++)
        par_b[i] = (^data_b[i*5 +: 5]) ^ ($urandom_range(0, 19) == 0);
      step();
      if (c == 200) pulse_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
